keypad_label_tx: RTL and testbench
==================================

# keypad_label_tx

Serial transmitter that drives the shuffled digit labels out to the ten keypad buttons. It is the output-side counterpart of the button encoder and display-shuffle path. The shuffle logic decides which digit each physical button represents; this block encodes those digits to seven-segment patterns and shifts them into a daisy-chained 8-bit shift-register/latch chain mounted behind the buttons. It sits between the display-shuffle register (label source) and the top-level pins, and the control unit starts it after every shuffle.

## Interface
Parameters:
- CLK_DIV, default 4: `clk` cycles per `ser_clk` half-period; legal range ≥1.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rstn`  in  1  reset, asynchronous, active-low.
- `labels`  in  40  nibble i (`[4i+3:4i]`) is the digit shown on button i.
- `blank`  in  1  sampled with `start`; 1 sends an all-dark frame.
- `start`  in  1  request one frame; accepted only in IDLE.
- `ser_data`  out  1  serial segment data, MSB first.
- `ser_clk`  out  1  shift clock; chain samples on rising edge.
- `ser_latch`  out  1  latch pulse; chain transfers shift to output on high.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse when a frame completes.

## Operation
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE with `start`=1:
  - capture `labels` and `blank` into an 80-bit frame register;
  - bit counter = 79, divider = 0;
  - go to SHIFT_LO.
- `start` in any other state is ignored. Changes to `labels` or `blank` after capture have no effect on the frame in progress.
- Frame layout: button 9 first, button 0 last (ends nearest the controller). Each button is 8 bits, order {dp,g,f,e,d,c,b,a}, active-high, MSB first.
- Encoding:
  - 0→0x3F, 1→0x06, 2→0x5B, 3→0x4F, 4→0x66, 5→0x6D, 6→0x7D, 7→0x07, 8→0x7F, 9→0x6F;
  - 0xA–0xE→0x40 (dash, error indication);
  - 0xF→0x00 (blank).
  - dp is always 0.
- `blank`=1: every byte is 0x00.
- SHIFT_LO:
  - `ser_clk`=0 and `ser_data` = frame bit[counter], held CLK_DIV cycles;
  - then go to SHIFT_HI.
- SHIFT_HI:
  - `ser_clk`=1 for CLK_DIV cycles;
  - then, if counter=0, go to LATCH; otherwise decrement counter and go to SHIFT_LO.
- LATCH:
  - `ser_latch`=1, `ser_clk`=0, `ser_data`=0 for CLK_DIV cycles;
  - then go to IDLE with `done`=1 for that first IDLE cycle.
- `busy` = (state ≠ IDLE), registered.
- The divider counts 0..CLK_DIV−1 and wraps; state transitions occur on wrap.

## Timing
- Reset (async, any state): state IDLE. `ser_data`, `ser_clk`, `ser_latch`, `busy` and `done` all go 0 immediately. Frame register and counters are cleared. A partial frame is abandoned and no latch is issued.
- All outputs are registered and glitch-free.
- `start` sampled at edge N: `busy`=1 and `ser_data`=bit 79 valid from edge N+1.
- Data is stable for CLK_DIV cycles before each `ser_clk` rise and for CLK_DIV cycles after it (changes only on entry to SHIFT_LO).
- `busy` stays high for exactly 161·CLK_DIV cycles: 80 bits × 2·CLK_DIV, plus CLK_DIV for the latch. With CLK_DIV=4 this is 644 cycles.
- `done` is asserted in the cycle `busy` first reads 0. A `start` in that same cycle is accepted (back-to-back frames, one idle cycle between).
- Exactly 80 `ser_clk` rising edges and exactly one `ser_latch` pulse per completed frame.

## Structure
- Shared package `doorlock_pkg`:
  - SEG_0..SEG_9, SEG_DASH, SEG_BLANK 8-bit constants;
  - N_BUTTONS=10, SEG_BITS=8;
  - state enum type.
- Sub-module `seg7_encode`: combinational 4-bit→8-bit encoder, instantiated 10× (or once per nibble in a generate loop) to build the frame at capture.
- Top body: frame register, 7-bit bit counter, divider counter, FSM, output registers.

## Test plan
- Reset: hold `rstn`=0 → all five outputs 0. Release, no `start` → outputs stay 0 for 1000 cycles.
- CLK_DIV=2, `labels`=0x9876543210, `start` pulse → bench shift model captures button 0=0x3F, button 1=0x06 … button 9=0x6F. `busy` lasts 322 cycles, one `ser_latch` of 2 cycles, `done` one pulse.
- Labels 0xFEDCBA0000 → buttons 4..8 = 0x40, button 9 = 0x00, buttons 0..3 = 0x3F. `blank`=1 with any labels → all 80 bits 0.
- `start` re-pulsed and `labels` changed at cycle 50 of a frame → no restart, original frame latched. `start` held through `done` cycle → second frame begins next edge.
- Reset asserted at bit 40 → outputs 0 same cycle, no `ser_latch`. A new `start` after release sends a complete correct frame.
- CLK_DIV=1 → 80 rising edges, `busy` = 161 cycles, data stable around every rise.

Source files
------------

// File: rtl/doorlock_pkg.sv
// Shared doorlock definitions: seven-segment patterns, keypad geometry and
// the label transmitter state type.
package doorlock_pkg;

    localparam int unsigned N_BUTTONS  = 10;
    localparam int unsigned SEG_BITS   = 8;
    localparam int unsigned NIB_BITS   = 4;
    localparam int unsigned FRAME_BITS = N_BUTTONS * SEG_BITS;
    localparam int unsigned CNT_BITS   = 7;

    // Segment order {dp,g,f,e,d,c,b,a}, active-high; dp never lit.
    localparam logic [SEG_BITS-1:0] SEG_0     = 8'h3F;
    localparam logic [SEG_BITS-1:0] SEG_1     = 8'h06;
    localparam logic [SEG_BITS-1:0] SEG_2     = 8'h5B;
    localparam logic [SEG_BITS-1:0] SEG_3     = 8'h4F;
    localparam logic [SEG_BITS-1:0] SEG_4     = 8'h66;
    localparam logic [SEG_BITS-1:0] SEG_5     = 8'h6D;
    localparam logic [SEG_BITS-1:0] SEG_6     = 8'h7D;
    localparam logic [SEG_BITS-1:0] SEG_7     = 8'h07;
    localparam logic [SEG_BITS-1:0] SEG_8     = 8'h7F;
    localparam logic [SEG_BITS-1:0] SEG_9     = 8'h6F;
    localparam logic [SEG_BITS-1:0] SEG_DASH  = 8'h40;
    localparam logic [SEG_BITS-1:0] SEG_BLANK = 8'h00;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

endpackage

// File: rtl/seg7_encode.sv
// Digit to seven-segment pattern; 0xA-0xE show a dash, 0xF is dark.
module seg7_encode
    import doorlock_pkg::*;
(
    input  logic [NIB_BITS-1:0] digit,
    output logic [SEG_BITS-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_DASH;
        case (digit)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            4'hF:    seg_c = SEG_BLANK;
            default: seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/keypad_label_tx.sv
// Shifts the ten encoded button labels into the daisy-chained segment
// registers behind the keypad, then pulses the chain latch.
module keypad_label_tx
    import doorlock_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [N_BUTTONS*NIB_BITS-1:0] labels,
    input  logic                          blank,
    input  logic                          start,
    output logic                          ser_data,
    output logic                          ser_clk,
    output logic                          ser_latch,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_BITS-1:0] BIT_FIRST = CNT_BITS'(FRAME_BITS - 1);

    state_t                state_q, state_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [CNT_BITS-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic                  ser_data_d, ser_clk_d, ser_latch_d, busy_d, done_d;
    logic [FRAME_BITS-1:0] enc_frame_c, cap_frame_c;
    logic                  div_wrap_c;

    // Button 9 lands in the top byte so it is shifted out first.
    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_enc
        seg7_encode u_enc (
            .digit (labels[NIB_BITS*i +: NIB_BITS]),
            .seg_c (enc_frame_c[SEG_BITS*i +: SEG_BITS])
        );
    end

    assign cap_frame_c = blank ? '0 : enc_frame_c;
    assign div_wrap_c  = (div_cnt_q == DIV_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            ser_data  <= 1'b0;
            ser_clk   <= 1'b0;
            ser_latch <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            ser_data  <= ser_data_d;
            ser_clk   <= ser_clk_d;
            ser_latch <= ser_latch_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // Next state plus the next value of every registered output.
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        bit_cnt_d  = bit_cnt_q;
        div_cnt_d  = '0;
        ser_data_d = ser_data;
        done_d     = 1'b0;

        if (state_q != IDLE && !div_wrap_c) begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        case (state_q)
            IDLE: begin
                ser_data_d = 1'b0;
                if (start) begin
                    frame_d    = cap_frame_c;
                    bit_cnt_d  = BIT_FIRST;
                    ser_data_d = cap_frame_c[FRAME_BITS-1];
                    state_d    = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_wrap_c) begin
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                // Data only moves when the low phase starts.
                if (div_wrap_c) begin
                    if (bit_cnt_q == '0) begin
                        ser_data_d = 1'b0;
                        state_d    = LATCH;
                    end else begin
                        bit_cnt_d  = bit_cnt_q - CNT_BITS'(1);
                        ser_data_d = frame_q[bit_cnt_d];
                        state_d    = SHIFT_LO;
                    end
                end
            end
            LATCH: begin
                if (div_wrap_c) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ser_clk_d   = (state_d == SHIFT_HI);
        ser_latch_d = (state_d == LATCH);
        busy_d      = (state_d != IDLE);
    end

endmodule

// File: tb/tb_keypad_label_tx.sv
// Bench for keypad_label_tx: a shift-chain model captures the serial stream,
// and frames expected at start are compared when the transmitter finishes.
module tb_keypad_label_tx;

    typedef struct {
        logic [39:0] labels;
        logic        blank;
        logic [79:0] frame;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [39:0] labels;
    logic        blank;
    logic        start     [2];
    logic        ser_data  [2];
    logic        ser_clk   [2];
    logic        ser_latch [2];
    logic        busy      [2];
    logic        done      [2];

    always #5 clk = ~clk;

    keypad_label_tx #(.CLK_DIV(2)) u_dut0 (
        .clk(clk), .rstn(rstn), .labels(labels), .blank(blank), .start(start[0]),
        .ser_data(ser_data[0]), .ser_clk(ser_clk[0]), .ser_latch(ser_latch[0]),
        .busy(busy[0]), .done(done[0])
    );

    keypad_label_tx #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .labels(labels), .blank(blank), .start(start[1]),
        .ser_data(ser_data[1]), .ser_clk(ser_clk[1]), .ser_latch(ser_latch[1]),
        .busy(busy[1]), .done(done[1])
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [79:0] exp_q0[$];
    logic [79:0] exp_q1[$];

    logic [79:0] shreg [2];
    logic [79:0] latched [2];
    logic [79:0] exp_f;
    int          run [2];
    int          rises [2];
    int          blen [2];
    int          lcnt [2];
    int          llen [2];
    int          total_latch [2];
    logic        p_clk [2];
    logic        p_data [2];
    logic        p_busy [2];
    logic        p_latch [2];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int div_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        logic [7:0] tbl [16];
        tbl = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                8'h7F, 8'h6F, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h00};
        return tbl[n];
    endfunction

    function automatic logic [79:0] model_frame(input logic [39:0] l, input logic b);
        logic [79:0] f;
        f = '0;
        for (int i = 0; i < 10; i++) begin
            f[8*i +: 8] = b ? 8'h00 : seg_of(l[4*i +: 4]);
        end
        return f;
    endfunction

    // Shift-chain model and per-frame protocol checks.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rstn) begin
                shreg[d] = '0; run[d] = 0; rises[d] = 0; blen[d] = 0;
                lcnt[d] = 0; llen[d] = 0;
                p_clk[d] = 1'b0; p_data[d] = 1'b0; p_busy[d] = 1'b0; p_latch[d] = 1'b0;
            end else begin
                run[d] = (ser_data[d] === p_data[d]) ? run[d] + 1 : 1;
                if (ser_clk[d] && !p_clk[d]) begin
                    rises[d]++;
                    shreg[d] = {shreg[d][78:0], ser_data[d]};
                    check($sformatf("setup_d%0d", d), 80'(run[d] >= div_of(d) + 1), 80'(1));
                end
                if (ser_clk[d] && p_clk[d]) begin
                    check($sformatf("hold_d%0d", d), 80'(ser_data[d]), 80'(p_data[d]));
                end
                if (ser_latch[d]) begin
                    check($sformatf("latch_quiet_d%0d", d), 80'({ser_clk[d], ser_data[d]}), 80'(0));
                    llen[d]++;
                    if (!p_latch[d]) begin
                        lcnt[d]++;
                        total_latch[d]++;
                        latched[d] = shreg[d];
                    end
                end
                if (busy[d]) blen[d]++;
                if (done[d] || (p_busy[d] && !busy[d])) begin
                    check($sformatf("done_d%0d", d), 80'(done[d]), 80'(p_busy[d] && !busy[d]));
                end
                if (p_busy[d] && !busy[d]) begin
                    check($sformatf("busy_len_d%0d", d), 80'(blen[d]), 80'(161 * div_of(d)));
                    check($sformatf("rises_d%0d", d), 80'(rises[d]), 80'(80));
                    check($sformatf("latch_cnt_d%0d", d), 80'(lcnt[d]), 80'(1));
                    check($sformatf("latch_len_d%0d", d), 80'(llen[d]), 80'(div_of(d)));
                    if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_frame_d%0d: got %0h expected none", d, latched[d]);
                    end else begin
                        exp_f = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check($sformatf("frame_d%0d", d), latched[d], exp_f);
                    end
                    rises[d] = 0; blen[d] = 0; lcnt[d] = 0; llen[d] = 0;
                end
                p_clk[d] = ser_clk[d]; p_data[d] = ser_data[d];
                p_busy[d] = busy[d]; p_latch[d] = ser_latch[d];
            end
        end
    end

    task automatic push_exp(input int d, input logic [79:0] f);
        if (d == 0) exp_q0.push_back(f);
        else        exp_q1.push_back(f);
    endtask

    task automatic wait_done(input int d);
        int t;
        t = 0;
        while (busy[d] && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("frame_timeout_d%0d", d), 80'(busy[d]), 80'(0));
        @(negedge clk);
    endtask

    task automatic send(input int d, input logic [39:0] l, input logic b, input logic [79:0] f);
        @(negedge clk);
        labels = l;
        blank = b;
        start[d] = 1'b1;
        push_exp(d, f);
        @(negedge clk);
        start[d] = 1'b0;
        wait_done(d);
    endtask

    task automatic check_quiet(input string name);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_d%0d", name, d),
                  80'({ser_data[d], ser_clk[d], ser_latch[d], busy[d], done[d]}), 80'(0));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [5];
        logic [39:0] l;
        int          tl;
        int          t;

        vecs[0] = '{40'h9876543210, 1'b0, 80'h6F7F077D6D664F5B063F};
        vecs[1] = '{40'hFEDCBA0000, 1'b0, 80'h0040404040403F3F3F3F};
        vecs[2] = '{40'h9876543210, 1'b1, 80'h0};
        vecs[3] = '{40'h0123456789, 1'b0, 80'h3F065B4F666D7D077F6F};
        vecs[4] = '{40'hFFFFFFFFFF, 1'b0, 80'h0};

        rstn = 1'b0; labels = '0; blank = 1'b0; start[0] = 1'b0; start[1] = 1'b0;
        total_latch[0] = 0; total_latch[1] = 0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_ser_data", 80'(ser_data[d]), 80'(0));
            check("rst_ser_clk", 80'(ser_clk[d]), 80'(0));
            check("rst_ser_latch", 80'(ser_latch[d]), 80'(0));
            check("rst_busy", 80'(busy[d]), 80'(0));
            check("rst_done", 80'(done[d]), 80'(0));
        end
        rstn = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            check_quiet("idle_quiet");
        end

        for (int i = 0; i < 5; i++) begin
            send(0, vecs[i].labels, vecs[i].blank, vecs[i].frame);
        end

        // Restart attempt and label change mid-frame must not disturb the frame.
        @(negedge clk);
        labels = 40'h9876543210; blank = 1'b0; start[0] = 1'b1;
        push_exp(0, 80'h6F7F077D6D664F5B063F);
        @(negedge clk);
        start[0] = 1'b0;
        repeat (49) @(negedge clk);
        labels = 40'hFFFFFFFFFF; blank = 1'b1; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0);
        blank = 1'b0;

        // Start held through the done cycle gives back-to-back frames.
        labels = 40'h0123456789;
        push_exp(0, 80'h3F065B4F666D7D077F6F);
        push_exp(0, 80'h3F065B4F666D7D077F6F);
        start[0] = 1'b1;
        @(negedge clk);
        t = 0;
        while (busy[0] && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("b2b_done", 80'(done[0]), 80'(1));
        @(negedge clk);
        check("b2b_restart", 80'(busy[0]), 80'(1));
        start[0] = 1'b0;
        wait_done(0);

        // Reset in the middle of a frame abandons it without a latch.
        @(negedge clk);
        labels = 40'h9876543210; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (160) @(negedge clk);
        tl = total_latch[0];
        #2 rstn = 1'b0;
        #1 check_quiet("rst_abort");
        repeat (5) @(negedge clk);
        check("rst_no_latch", 80'(total_latch[0]), 80'(tl));
        rstn = 1'b1;
        send(0, 40'h0123456789, 1'b0, 80'h3F065B4F666D7D077F6F);

        // Minimum divider.
        send(1, 40'h9876543210, 1'b0, 80'h6F7F077D6D664F5B063F);
        send(1, 40'hFEDCBA0000, 1'b0, 80'h0040404040403F3F3F3F);
        for (int i = 0; i < 3; i++) begin
            l = {8'($urandom), 32'($urandom)};
            send(1, l, 1'b0, model_frame(l, 1'b0));
            send(0, l, 1'b0, model_frame(l, 1'b0));
        end

        repeat (5) @(negedge clk);
        check("pending_q0", 80'(exp_q0.size()), 80'(0));
        check("pending_q1", 80'(exp_q1.size()), 80'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
